// File: rtl/ctrl_issue_pkg.sv
// ctrl_issue_pkg: shared types and constants for the control-code issuer.
// Code bit i drives control decoder input pi<i>.
package ctrl_issue_pkg;

  localparam int CODE_W    = 7;
  // Repeat-count width of the stored FIFO entry; the issuer's CNT_W follows it.
  localparam int CNT_W_DEF = 4;

  localparam int CODE_B0 = 0;
  localparam int CODE_B1 = 1;
  localparam int CODE_B2 = 2;
  localparam int CODE_B3 = 3;
  localparam int CODE_B4 = 4;
  localparam int CODE_B5 = 5;
  localparam int CODE_B6 = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0]    code;
    logic [CNT_W_DEF-1:0] rpt;
  } entry_t;

endpackage

// File: rtl/ctrl_code_issuer_if.sv
// ctrl_code_issuer_if: request port (sequencer -> issuer) and beat port
// (issuer -> decoder). Parity signals exist only with CTRL_ISSUE_PARITY_EN.
interface ctrl_code_issuer_if #(
  parameter int CNT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_code;
  logic [CNT_W-1:0] req_repeat;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_code;
  logic             out_last;
`ifdef CTRL_ISSUE_PARITY_EN
  logic             req_par;
  logic             out_par;
`endif

  // Environment side: sequencer plus decoder
  modport master (
    output req_valid, req_code, req_repeat, out_ready,
`ifdef CTRL_ISSUE_PARITY_EN
    output req_par,
    input  out_par,
`endif
    input  req_ready, out_valid, out_code, out_last
  );

  // Issuer side
  modport slave (
    input  req_valid, req_code, req_repeat, out_ready,
`ifdef CTRL_ISSUE_PARITY_EN
    input  req_par,
    output out_par,
`endif
    output req_ready, out_valid, out_code, out_last
  );
endinterface

// File: rtl/ctrl_issue_fifo.sv
// ctrl_issue_fifo: synchronous FIFO, DEPTH a power of two, with flush.
// Pointers carry one extra wrap bit to separate full from empty.
module ctrl_issue_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp, rp;
  T            mem [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata   = mem[rp[AW-1:0]];

  // Pointer update; flush discards all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ctrl_code_issuer.sv
// ctrl_code_issuer: buffers {code, repeat} requests and issues each code
// repeat+1 times to the control decoder, marking the final beat.
// Optional feature macro: CTRL_ISSUE_PARITY_EN (req_par check, out_par).
module ctrl_code_issuer
  import ctrl_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                busy,
  ctrl_code_issuer_if.slave   bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] code_q;
  entry_t            wr_ent, rd_ent;
  logic              full, empty;
  logic              push, pop, beat, cnt_zero, par_ok;

  assign beat     = (state_q == ISSUE) && bus.out_ready;
  assign cnt_zero = (cnt_q == '0);

`ifdef CTRL_ISSUE_PARITY_EN
  logic par_q;
  // Bad-parity requests are handshaken but never stored
  assign par_ok      = ((^bus.req_code) == bus.req_par);
  assign bus.out_par = par_q;
`else
  assign par_ok = 1'b1;
`endif

  // No write bypass: a full FIFO refuses even if it pops this cycle
  assign bus.req_ready = !full;
  assign push = bus.req_valid && !full && !flush && par_ok;
  // Load the hold regs from IDLE, or chain the next entry on the last beat
  assign pop  = !flush && !empty &&
                ((state_q == IDLE) || (beat && cnt_zero));

  assign wr_ent.code = bus.req_code;
  assign wr_ent.rpt  = CNT_W_DEF'(bus.req_repeat);

  ctrl_issue_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (rd_ent),
    .full  (full),
    .empty (empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!empty) state_d = ISSUE;
        ISSUE:   if (beat && cnt_zero && empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; out_last is decoded so it cannot disagree with cnt
  always_comb begin
    bus.out_valid = (state_q == ISSUE);
    bus.out_last  = (state_q == ISSUE) && cnt_zero;
    bus.out_code  = code_q;
    busy          = (state_q == ISSUE) || !empty;
  end

  // Hold registers: load on pop, count down on accepted non-final beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      cnt_q  <= '0;
`ifdef CTRL_ISSUE_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (flush) begin
      code_q <= '0;
      cnt_q  <= '0;
`ifdef CTRL_ISSUE_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (pop) begin
      code_q <= rd_ent.code;
      cnt_q  <= CNT_W'(rd_ent.rpt);
`ifdef CTRL_ISSUE_PARITY_EN
      par_q  <= ^rd_ent.code;
`endif
    end else if (beat && !cnt_zero) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_ctrl_code_issuer.sv
// tb_ctrl_code_issuer: directed vectors with hand-computed expectations.
module tb_ctrl_code_issuer;
  logic clk = 1'b0;
  logic rst_n, flush, busy;
  int   n_chk = 0;
  int   n_fail = 0;
  int   beats;

  ctrl_code_issuer_if #(.CNT_W(4)) bus ();

  ctrl_code_issuer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] code, input logic [3:0] rpt);
    bus.req_valid  = 1'b1;
    bus.req_code   = code;
    bus.req_repeat = rpt;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_code   = '0;
    bus.req_repeat = '0;
    bus.out_ready  = 1'b0;
`ifdef CTRL_ISSUE_PARITY_EN
    bus.req_par    = 1'b0;
`endif
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_code",  bus.out_code,  0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_busy",      busy,          0);
    chk("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single request: visible 2 clocks after accept
    bus.out_ready = 1'b1;
    req(7'h1C, 4'd0);
    tick();                       // E0: accepted
    bus.req_valid = 1'b0;
    chk("t1_valid_e0", bus.out_valid, 0);
    chk("t1_busy_e0",  busy, 1);
    tick();                       // E1
    chk("t1_valid_e1", bus.out_valid, 1);
    chk("t1_code",     bus.out_code, 7'h1C);
    chk("t1_last",     bus.out_last, 1);
    tick();                       // consumed, FIFO empty
    chk("t1_valid_end", bus.out_valid, 0);
    chk("t1_busy_end",  busy, 0);

    // repeat=3 with out_ready toggling
    bus.out_ready = 1'b0;
    req(7'h05, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    beats = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.out_ready = (cyc % 2 == 0);
      if (bus.out_valid) begin
        chk("t2_code", bus.out_code, 7'h05);
        chk("t2_last", bus.out_last, (beats == 3));
        if (bus.out_ready) beats++;
      end
      tick();
    end
    chk("t2_beats", beats, 4);
    chk("t2_idle",  bus.out_valid, 0);

    // Five requests while stalled: the first moves into the hold regs,
    // so the 4-entry FIFO fills on the fifth accept
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      req(7'(i), 4'd0);
      tick();
      chk("t3_req_ready", bus.req_ready, (i < 5));
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_code",  bus.out_code, i);
      chk("t3_last",  bus.out_last, 1);
      tick();
    end
    chk("t3_drained", bus.out_valid, 0);
    chk("t3_busy",    busy, 0);

    // Flush mid-burst with a simultaneous push
    bus.out_ready = 1'b0;
    req(7'h2A, 4'd7); tick();
    req(7'h11, 4'd0); tick();
    req(7'h22, 4'd0); tick();
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();       // 3 beats done, cnt now 4
    chk("t4_mid_valid", bus.out_valid, 1);
    chk("t4_mid_code",  bus.out_code, 7'h2A);
    chk("t4_mid_last",  bus.out_last, 0);
    flush = 1'b1;
    req(7'h33, 4'd0);
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_busy",  busy, 0);
    chk("t4_ready", bus.req_ready, 1);
    tick(); tick();
    chk("t4_lost", bus.out_valid | busy, 0);

    // Maximum repeat: 16 beats, no wrap
    bus.out_ready = 1'b1;
    req(7'h7F, 4'd15);
    tick();
    bus.req_valid = 1'b0;
    tick();
    beats = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!bus.out_valid) break;
      chk("t5_last", bus.out_last, (beats == 15));
      beats++;
      tick();
    end
    chk("t5_beats", beats, 16);
    chk("t5_idle",  bus.out_valid, 0);

    // Async reset mid-burst
    req(7'h4F, 4'd5);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    chk("t6_pre_valid", bus.out_valid, 1);
    chk("t6_pre_code",  bus.out_code, 7'h4F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_code",  bus.out_code, 0);
    chk("t6_last",  bus.out_last, 0);
    chk("t6_busy",  busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_post", bus.out_valid | busy, 0);

`ifdef CTRL_ISSUE_PARITY_EN
    // Wrong parity accepted but dropped; correct parity issued
    req(7'h03, 4'd0);
    bus.req_par = 1'b1;
    chk("t7_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    chk("t7_dropped", bus.out_valid | busy, 0);
    req(7'h07, 4'd0);
    bus.req_par = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("t7_valid", bus.out_valid, 1);
    chk("t7_code",  bus.out_code, 7'h07);
    chk("t7_par",   bus.out_par, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
